// File: rtl/matmul_seq_pkg.sv
// Shared constants and state encoding for the GEMM tile-loop sequencer.
package matmul_seq_pkg;

    localparam int TILE_DEF         = 8;
    localparam int LOG2_TILE_DEF    = 3;
    localparam int AWIDTH_DEF       = 16;
    localparam int STRIDE_WIDTH_DEF = 16;
    localparam int DIM_WIDTH_DEF    = 12;
    localparam int OPS_WIDTH        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PE_CLR,
        ST_LAUNCH,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/tile_edge_mask.sv
// Edge validity mask for one tile dimension: lane i is set when element
// idx*TILE + i still lies inside a matrix dimension of size dim.
module tile_edge_mask
    import matmul_seq_pkg::*;
#(
    parameter int TILE      = TILE_DEF,
    parameter int LOG2_TILE = LOG2_TILE_DEF,
    parameter int DIM_WIDTH = DIM_WIDTH_DEF
) (
    input  logic [DIM_WIDTH-1:0] i_dim,
    input  logic [DIM_WIDTH-1:0] i_idx,
    output logic [TILE-1:0]      o_mask
);

    localparam int EW = DIM_WIDTH + LOG2_TILE + 1;

    logic [EW-1:0] w_first;

    assign w_first = EW'(i_idx) << LOG2_TILE;

    // A lane is live while its absolute element index is below the dimension
    always_comb begin
        o_mask = '0;
        for (int i = 0; i < TILE; i++) begin
            o_mask[i] = (w_first + EW'(i)) < EW'(i_dim);
        end
    end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Tile-loop controller: walks an MxNxK GEMM as TILE^3 slice operations,
// issuing tile base addresses, edge masks, PE clear/accumulate control and
// a start/done handshake to one matmul slice.
module matmul_tile_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int TILE         = TILE_DEF,
    parameter int LOG2_TILE    = LOG2_TILE_DEF,
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int STRIDE_WIDTH = STRIDE_WIDTH_DEF,
    parameter int DIM_WIDTH    = DIM_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start_reg,
    input  logic                    clear_done_reg,
    input  logic                    abort,
    input  logic [DIM_WIDTH-1:0]    dim_m,
    input  logic [DIM_WIDTH-1:0]    dim_n,
    input  logic [DIM_WIDTH-1:0]    dim_k,
    input  logic [AWIDTH-1:0]       base_a,
    input  logic [AWIDTH-1:0]       base_b,
    input  logic [AWIDTH-1:0]       base_c,
    input  logic [STRIDE_WIDTH-1:0] stride_a,
    input  logic [STRIDE_WIDTH-1:0] stride_b,
    input  logic [STRIDE_WIDTH-1:0] stride_c,
    output logic                    slice_start,
    input  logic                    slice_done,
    output logic                    slice_pe_resetn,
    output logic                    slice_c_wr_en,
    output logic [AWIDTH-1:0]       address_mat_a,
    output logic [AWIDTH-1:0]       address_mat_b,
    output logic [AWIDTH-1:0]       address_mat_c,
    output logic [TILE-1:0]         validity_mask_a_rows,
    output logic [TILE-1:0]         validity_mask_a_cols_b_rows,
    output logic [TILE-1:0]         validity_mask_b_cols,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [OPS_WIDTH-1:0]    tile_ops
);

    localparam int CW = DIM_WIDTH + 1;

    seq_state_t r_state;
    seq_state_t w_stateNext;

    logic [DIM_WIDTH-1:0]    r_dimM, r_dimN, r_dimK;
    logic [AWIDTH-1:0]       r_baseA, r_baseB, r_baseC;
    logic [STRIDE_WIDTH-1:0] r_strideA, r_strideB, r_strideC;

    logic [DIM_WIDTH-1:0] r_mt, r_nt, r_kt;
    logic [AWIDTH-1:0]    r_aRowOff, r_bRowOff, r_cRowOff;
    logic [AWIDTH-1:0]    r_kColOff, r_nColOff;

    logic [CW-1:0]     w_tilesM, w_tilesN, w_tilesK;
    logic              w_lastM, w_lastN, w_lastK, w_zeroDim;
    logic [AWIDTH-1:0] w_stepA, w_stepB, w_stepC, w_tileStep;
    logic [TILE-1:0]   w_maskRows, w_maskK, w_maskCols;

    logic w_latch, w_zeroIdx, w_load, w_opDone, w_step, w_setErr;

    assign w_tilesM = (CW'(r_dimM) + CW'(TILE - 1)) >> LOG2_TILE;
    assign w_tilesN = (CW'(r_dimN) + CW'(TILE - 1)) >> LOG2_TILE;
    assign w_tilesK = (CW'(r_dimK) + CW'(TILE - 1)) >> LOG2_TILE;

    assign w_lastM = ({1'b0, r_mt} == (w_tilesM - CW'(1)));
    assign w_lastN = ({1'b0, r_nt} == (w_tilesN - CW'(1)));
    assign w_lastK = ({1'b0, r_kt} == (w_tilesK - CW'(1)));

    assign w_zeroDim = (r_dimM == '0) || (r_dimN == '0) || (r_dimK == '0);

    assign w_stepA    = AWIDTH'({r_strideA, {LOG2_TILE{1'b0}}});
    assign w_stepB    = AWIDTH'({r_strideB, {LOG2_TILE{1'b0}}});
    assign w_stepC    = AWIDTH'({r_strideC, {LOG2_TILE{1'b0}}});
    assign w_tileStep = AWIDTH'(TILE);

    tile_edge_mask #(.TILE(TILE), .LOG2_TILE(LOG2_TILE), .DIM_WIDTH(DIM_WIDTH)) u_maskRows (
        .i_dim  (r_dimM),
        .i_idx  (r_mt),
        .o_mask (w_maskRows)
    );

    tile_edge_mask #(.TILE(TILE), .LOG2_TILE(LOG2_TILE), .DIM_WIDTH(DIM_WIDTH)) u_maskK (
        .i_dim  (r_dimK),
        .i_idx  (r_kt),
        .o_mask (w_maskK)
    );

    tile_edge_mask #(.TILE(TILE), .LOG2_TILE(LOG2_TILE), .DIM_WIDTH(DIM_WIDTH)) u_maskCols (
        .i_dim  (r_dimN),
        .i_idx  (r_nt),
        .o_mask (w_maskCols)
    );

    // Next-state and per-cycle control strobes; abort overrides everything
    always_comb begin
        w_stateNext = r_state;
        w_latch     = 1'b0;
        w_zeroIdx   = 1'b0;
        w_load      = 1'b0;
        w_opDone    = 1'b0;
        w_step      = 1'b0;
        w_setErr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_reg) begin
                    w_latch     = 1'b1;
                    w_stateNext = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_zeroDim) begin
                    w_setErr    = 1'b1;
                    w_stateNext = ST_DONE;
                end else begin
                    w_zeroIdx   = 1'b1;
                    w_stateNext = ST_PE_CLR;
                end
            end
            ST_PE_CLR: begin
                w_stateNext = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                w_load      = 1'b1;
                w_stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (slice_done) begin
                    w_opDone    = 1'b1;
                    w_stateNext = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (!slice_done) begin
                    w_step = 1'b1;
                    if (w_lastK && w_lastN && w_lastM) begin
                        w_stateNext = ST_DONE;
                    end else if (w_lastK) begin
                        w_stateNext = ST_PE_CLR;
                    end else begin
                        w_stateNext = ST_LAUNCH;
                    end
                end
            end
            ST_DONE: begin
                if (clear_done_reg) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_stateNext = ST_IDLE;
            w_zeroIdx   = 1'b0;
            w_load      = 1'b0;
            w_opDone    = 1'b0;
            w_step      = 1'b0;
            w_setErr    = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Job configuration is captured once at start so host writes mid-job are harmless
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dimM    <= '0;
            r_dimN    <= '0;
            r_dimK    <= '0;
            r_baseA   <= '0;
            r_baseB   <= '0;
            r_baseC   <= '0;
            r_strideA <= '0;
            r_strideB <= '0;
            r_strideC <= '0;
        end else if (w_latch) begin
            r_dimM    <= dim_m;
            r_dimN    <= dim_n;
            r_dimK    <= dim_k;
            r_baseA   <= base_a;
            r_baseB   <= base_b;
            r_baseC   <= base_c;
            r_strideA <= stride_a;
            r_strideB <= stride_b;
            r_strideC <= stride_c;
        end
    end

    // Loop indices with running address offsets, so no multiplier is needed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mt      <= '0;
            r_nt      <= '0;
            r_kt      <= '0;
            r_aRowOff <= '0;
            r_bRowOff <= '0;
            r_cRowOff <= '0;
            r_kColOff <= '0;
            r_nColOff <= '0;
        end else if (w_zeroIdx) begin
            r_mt      <= '0;
            r_nt      <= '0;
            r_kt      <= '0;
            r_aRowOff <= '0;
            r_bRowOff <= '0;
            r_cRowOff <= '0;
            r_kColOff <= '0;
            r_nColOff <= '0;
        end else if (w_step) begin
            if (!w_lastK) begin
                r_kt      <= r_kt + DIM_WIDTH'(1);
                r_kColOff <= r_kColOff + w_tileStep;
                r_bRowOff <= r_bRowOff + w_stepB;
            end else begin
                r_kt      <= '0;
                r_kColOff <= '0;
                r_bRowOff <= '0;
                if (!w_lastN) begin
                    r_nt      <= r_nt + DIM_WIDTH'(1);
                    r_nColOff <= r_nColOff + w_tileStep;
                end else begin
                    r_nt      <= '0;
                    r_nColOff <= '0;
                    r_mt      <= r_mt + DIM_WIDTH'(1);
                    r_aRowOff <= r_aRowOff + w_stepA;
                    r_cRowOff <= r_cRowOff + w_stepC;
                end
            end
        end
    end

    // Slice-facing and status outputs, registered from the upcoming state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slice_start                 <= 1'b0;
            slice_pe_resetn             <= 1'b1;
            slice_c_wr_en               <= 1'b0;
            address_mat_a               <= '0;
            address_mat_b               <= '0;
            address_mat_c               <= '0;
            validity_mask_a_rows        <= '0;
            validity_mask_a_cols_b_rows <= '0;
            validity_mask_b_cols        <= '0;
            busy                        <= 1'b0;
            done                        <= 1'b0;
            err                         <= 1'b0;
        end else begin
            slice_start     <= (w_stateNext == ST_WAIT);
            slice_pe_resetn <= (w_stateNext != ST_PE_CLR);
            busy            <= (w_stateNext inside {ST_CHECK, ST_PE_CLR, ST_LAUNCH, ST_WAIT, ST_ADVANCE});
            done            <= (w_stateNext == ST_DONE);
            if (w_setErr) begin
                err <= 1'b1;
            end else if (w_stateNext == ST_IDLE) begin
                err <= 1'b0;
            end
            if (w_load) begin
                address_mat_a               <= r_baseA + r_aRowOff + r_kColOff;
                address_mat_b               <= r_baseB + r_bRowOff + r_nColOff;
                address_mat_c               <= r_baseC + r_cRowOff + r_nColOff;
                validity_mask_a_rows        <= w_maskRows;
                validity_mask_a_cols_b_rows <= w_maskK;
                validity_mask_b_cols        <= w_maskCols;
                slice_c_wr_en               <= w_lastK;
            end else if (w_stateNext == ST_IDLE) begin
                slice_c_wr_en <= 1'b0;
            end
        end
    end

    // Completed-operation counter; restarts with each new job
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tile_ops <= '0;
        end else if (w_latch) begin
            tile_ops <= '0;
        end else if (w_opDone) begin
            tile_ops <= tile_ops + OPS_WIDTH'(1);
        end
    end

endmodule
